uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial receiver that consumes the UART_TX line format: 1 start bit (0), IN_data data bits LSB first, an optional parity bit, and 1 stop bit (1). It sits directly downstream of the transmitter's TX_OUT, oversamples RX_IN at a runtime-selectable prescale, and decides each bit by majority vote. It presents the parallel byte with a one-cycle valid strobe and flags parity and stop errors. Parity configuration matches the transmitter: PAR_EN enables parity, PAR_TYP=0 selects even, PAR_TYP=1 selects odd.

Parameters:
IN_data, 8, data bits per frame (P_DATA width).

Ports:
clk  input  1  system clock; oversampling clock, Prescale ticks per bit.
RST  input  1  asynchronous, active-high reset.
RX_IN  input  1  serial line, idle high; already synchronous to clk (the synchronizer is outside this block).
PAR_EN  input  1  1 = frame carries a parity bit.
PAR_TYP  input  1  0 = even, 1 = odd.
Prescale  input  6  oversampling ratio; legal values are 8, 16 and 32.
P_DATA  output  IN_data  last correctly received word.
data_valid  output  1  one-cycle strobe when P_DATA updates.
par_err  output  1  one-cycle strobe on parity mismatch.
stp_err  output  1  one-cycle strobe on stop bit sampled 0.

Behaviour:
- Reset (async, RST=1): state IDLE, all counters 0, P_DATA=0, data_valid=0, par_err=0, stp_err=0. Reset mid-frame abandons the frame with no strobes.
- Counters: edge_cnt runs 0..Prescale-1 within each bit; bit_cnt advances when edge_cnt wraps.
- Sampling: take RX_IN at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1. The bit value is the majority of the three, latched at edge_cnt = Prescale/2+2.
- Configuration: PAR_EN, PAR_TYP and Prescale are latched when leaving IDLE. Changes mid-frame are ignored.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: RX_IN=0 moves to START with edge_cnt=0 on the next cycle.
- START: if the voted bit is 1, treat it as a glitch and return to IDLE at the end of the bit, with no strobes. Otherwise go to DATA at the end of the bit.
- DATA: shift the voted bit into the shift-register MSB and shift right, so the result is LSB first. After IN_data bits, go to PARITY if PAR_EN, else STOP.
- PARITY: compute the expected bit as XOR of the data bits, inverted if PAR_TYP=1. On mismatch, par_err pulses for 1 cycle at the end of the parity bit and the frame is marked bad. Always proceed to STOP.
- STOP: at the end of the stop bit (edge_cnt=Prescale-1 registered), the next cycle produces exactly one of two outcomes:
  - stp_err=1 if the voted stop bit is 0;
  - otherwise, if the frame is not bad, data_valid=1 and P_DATA is loaded.
- A bad frame never updates P_DATA and never raises data_valid. P_DATA holds its value between strobes.
- Leaving STOP: go to START directly if RX_IN=0 in the last stop cycle, so back-to-back frames are accepted with zero idle. Otherwise go to IDLE.
- Latency: data_valid asserts (2+IN_data+PAR_EN)*Prescale cycles after the start-detect cycle, plus 1.
- Simultaneous events: par_err and stp_err can both pulse in one frame, in different cycles. data_valid is never high in the same cycle as either error.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - parity constants PAR_EVEN=0 and PAR_ODD=1, shared with parity_calc on the TX side;
  - the legal prescale constants 8, 16 and 32.
- One sub-module is natural: rx_sampler, which owns edge_cnt, the three sample taps and the majority vote. It outputs the sampled bit, a bit_tick and an end-of-bit tick.
- The FSM, shift register and parity/stop checks stay in uart_rx.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0, frame carrying 0xA5 (parity 0) -> P_DATA=0xA5; data_valid pulses 1 cycle, 89 cycles after the start edge; no errors.
- Prescale=16, PAR_EN=1, PAR_TYP=1, 0x3C sent with the wrong parity bit 0 -> par_err pulses once; data_valid stays 0; P_DATA keeps its previous value.
- Prescale=32, PAR_EN=0, 0xFF with stop bit driven 0 -> stp_err pulses once; no data_valid.
- Prescale=8, a 3-cycle low glitch on idle RX_IN -> FSM returns to IDLE; no strobes.
- Prescale=8, one sample flipped per bit at tap Prescale/2 -> majority vote still recovers 0x5A.
- Back-to-back frames 0x12 then 0x34 with zero idle, then RST asserted mid-third frame -> two data_valid pulses with the correct P_DATA; all outputs 0 after reset; no strobe from the aborted frame.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and constants: receiver state encoding,
//               parity-type codes and the legal oversampling ratios.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Parity type codes, common to the transmit-side parity generator
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Supported oversampling ratios
    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    // Two-out-of-three majority vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_sampler.sv
`default_nettype none
// ============================================================================
// Module      : rx_sampler
// Description : Per-bit oversampling counter. Captures the line at the three
//               taps around mid-bit and provides the majority-voted bit, a
//               tick when that vote is ready and a tick on the last
//               oversample of the bit.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_sampler
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       RST,
    input  logic       run_i,
    input  logic [5:0] prescale_i,
    input  logic       rx_i,
    output logic       bit_o,
    output logic       bit_tick_o,
    output logic       eob_tick_o
);

    logic [5:0] edge_cnt_q;
    logic [5:0] edge_cnt_d;
    logic [2:0] taps_q;
    logic [5:0] w_half;
    logic [5:0] w_last;

    assign w_half = {1'b0, prescale_i[5:1]};
    assign w_last = prescale_i - 6'd1;

    // Oversample counter: held at 0 while idle, wraps at the end of each bit
    always_comb begin
        edge_cnt_d = 6'd0;
        if (run_i && (edge_cnt_q != w_last)) begin
            edge_cnt_d = edge_cnt_q + 6'd1;
        end
    end

    // Counter register and the three mid-bit sample taps
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            edge_cnt_q <= 6'd0;
            taps_q     <= 3'b000;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            if (run_i) begin
                if (edge_cnt_q == w_half - 6'd1) taps_q[0] <= rx_i;
                if (edge_cnt_q == w_half)        taps_q[1] <= rx_i;
                if (edge_cnt_q == w_half + 6'd1) taps_q[2] <= rx_i;
            end
        end
    end

    assign bit_o      = maj3(taps_q[0], taps_q[1], taps_q[2]);
    assign bit_tick_o = run_i && (edge_cnt_q == w_half + 6'd2);
    assign eob_tick_o = run_i && (edge_cnt_q == w_last);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver: start/data/parity/stop framing with majority
//               voted bits, parity and stop checking, parallel output with a
//               one-cycle valid strobe and one-cycle error strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int IN_data = 8
)
(
    input  logic               clk,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic [5:0]         Prescale,
    output logic [IN_data-1:0] P_DATA,
    output logic               data_valid,
    output logic               par_err,
    output logic               stp_err
);

    localparam int CNT_W = (IN_data > 1) ? $clog2(IN_data) : 1;

    rx_state_e          state_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [IN_data-1:0] shift_q;
    logic [IN_data-1:0] p_data_q;
    logic               bit_q;
    logic               bad_q;
    logic               par_en_q;
    logic               par_typ_q;
    logic [5:0]         prescale_q;
    logic               fin_ok_q;
    logic               fin_stp_q;
    logic               data_valid_q;
    logic               par_err_q;
    logic               stp_err_q;

    logic               w_bit;
    logic               w_bit_tick;
    logic               w_eob;
    logic               w_exp_par;

    rx_sampler u_sampler (
        .clk        (clk),
        .RST        (RST),
        .run_i      (state_q != IDLE),
        .prescale_i (prescale_q),
        .rx_i       (RX_IN),
        .bit_o      (w_bit),
        .bit_tick_o (w_bit_tick),
        .eob_tick_o (w_eob)
    );

    assign w_exp_par = (^shift_q) ^ (par_typ_q == PAR_ODD);

    // Frame FSM; the frame outcome is captured at the end of the stop bit and
    // turned into a strobe on the following cycle, even if a new frame starts
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            bit_q        <= 1'b0;
            bad_q        <= 1'b0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            prescale_q   <= PRESCALE_8;
            fin_ok_q     <= 1'b0;
            fin_stp_q    <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            fin_ok_q     <= 1'b0;
            fin_stp_q    <= 1'b0;

            if (fin_ok_q) begin
                data_valid_q <= 1'b1;
                p_data_q     <= shift_q;
            end
            if (fin_stp_q) begin
                stp_err_q <= 1'b1;
            end

            if (w_bit_tick) begin
                bit_q <= w_bit;
            end

            case (state_q)
                IDLE: begin
                    if (!RX_IN) begin
                        state_q    <= START;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        prescale_q <= Prescale;
                        bad_q      <= 1'b0;
                        bit_cnt_q  <= '0;
                    end
                end
                START: begin
                    if (w_eob) begin
                        state_q <= bit_q ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (w_bit_tick) begin
                        shift_q <= {w_bit, shift_q[IN_data-1:1]};
                    end
                    if (w_eob) begin
                        if (bit_cnt_q == CNT_W'(IN_data - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (w_eob) begin
                        if (bit_q != w_exp_par) begin
                            par_err_q <= 1'b1;
                            bad_q     <= 1'b1;
                        end
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (w_eob) begin
                        fin_stp_q <= !bit_q;
                        fin_ok_q  <= bit_q && !bad_q;
                        if (!RX_IN) begin
                            state_q <= START;
                            bad_q   <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. Frames are generated from
//               random or directed content; the expected strobes (kind,
//               cycle, P_DATA) are pushed into a scoreboard when a frame
//               starts and a monitor compares them as the DUT strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
    import uart_pkg::*;

    localparam int N    = 8;
    localparam int FULL = 1 << 30;

    localparam logic [31:0] K_VALID = 32'd1;
    localparam logic [31:0] K_PAR   = 32'd2;
    localparam logic [31:0] K_STP   = 32'd4;

    logic         clk = 1'b0;
    logic         RST;
    logic         RX_IN;
    logic         PAR_EN;
    logic         PAR_TYP;
    logic [5:0]   Prescale;
    logic [N-1:0] P_DATA;
    logic         data_valid;
    logic         par_err;
    logic         stp_err;

    always #5 clk = ~clk;

    uart_rx #(.IN_data(N)) dut (
        .clk        (clk),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    typedef struct {
        logic [31:0]  kind;
        int           cyc;
        logic [N-1:0] data;
    } ev_t;

    ev_t          sb[$];
    int           vectors     = 0;
    int           miscompares = 0;
    int           cyc         = 0;
    logic [N-1:0] model_pdata;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_p_data"},     32'(P_DATA),     32'd0);
        check({tag, "_data_valid"}, 32'(data_valid), 32'd0);
        check({tag, "_par_err"},    32'(par_err),    32'd0);
        check({tag, "_stp_err"},    32'(stp_err),    32'd0);
    endtask

    function automatic logic [5:0] rand_presc();
        case ($urandom_range(0, 2))
            0:       return PRESCALE_8;
            1:       return PRESCALE_16;
            default: return PRESCALE_32;
        endcase
    endfunction

    // Monitor: every strobe must match the oldest outstanding expectation
    initial begin : monitor
        ev_t        e;
        logic [2:0] k;
        forever begin
            @(negedge clk);
            if (!RST && (data_valid || par_err || stp_err)) begin
                k = {stp_err, par_err, data_valid};
                if (sb.size() == 0) begin
                    check("unexpected_strobe", 32'(k), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("strobe_kind",  32'(k),      e.kind);
                    check("strobe_cycle", 32'(cyc),    32'(e.cyc));
                    check("p_data",       32'(P_DATA), 32'(e.data));
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            RX_IN = 1'b1;
        end
    endtask

    // Drive one frame. Expectations follow directly from the frame content:
    // parity error at the end of the parity bit, then either a stop error or
    // (if parity held) a valid word one cycle after the end of the stop bit.
    task automatic send_frame(input logic [N-1:0] d, input int p, input bit pe, input bit pt,
                              input bit bad_par, input bit bad_stop, input bit flip,
                              input int limit);
        int          nb;
        int          s;
        int          c;
        logic [15:0] bits;
        logic        pbit;
        ev_t         e;
        nb   = 2 + N + (pe ? 1 : 0);
        pbit = (^d) ^ pt;
        if (bad_par) pbit = ~pbit;
        bits = 16'hFFFF;
        bits[0] = 1'b0;
        for (int i = 0; i < N; i++) bits[1 + i] = d[i];
        if (pe) bits[N + 1] = pbit;
        bits[nb - 1] = ~bad_stop;
        c = 0;
        s = 0;
        for (int b = 0; b < nb; b++) begin
            for (int o = 0; o < p; o++) begin
                if (c == limit) return;
                @(negedge clk);
                if (c == 0) begin
                    s        = cyc + 1;
                    PAR_EN   = pe;
                    PAR_TYP  = pt;
                    Prescale = 6'(p);
                    if (limit >= nb * p) begin
                        if (pe && bad_par) begin
                            e.kind = K_PAR; e.cyc = s + (N + 2) * p; e.data = model_pdata;
                            sb.push_back(e);
                        end
                        if (bad_stop) begin
                            e.kind = K_STP; e.cyc = s + nb * p + 1; e.data = model_pdata;
                            sb.push_back(e);
                        end else if (!(pe && bad_par)) begin
                            e.kind = K_VALID; e.cyc = s + nb * p + 1; e.data = d;
                            sb.push_back(e);
                            model_pdata = d;
                        end
                    end
                end else if (c == 1) begin
                    PAR_EN   = 1'($urandom);
                    PAR_TYP  = 1'($urandom);
                    Prescale = rand_presc();
                end
                RX_IN = (flip && (o == p / 2 + 1)) ? ~bits[b] : bits[b];
                c++;
            end
        end
    endtask

    task automatic glitch(input int len, input int p);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0) Prescale = 6'(p);
            RX_IN = 1'b0;
        end
        idle(p + 3);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int       p;
        int       gap;
        bit       pe;
        bit       pt;
        bit       b2b;
        logic [N-1:0] d;

        RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = PRESCALE_8;
        model_pdata = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        RST = 1'b0;
        idle(5);

        // Directed frames
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FULL);
        idle(3);
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, FULL);
        idle(3);
        send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FULL);
        idle(3);
        glitch(3, 8);
        send_frame(8'h5A, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, FULL);
        idle(3);

        // Back-to-back pair, then a frame abandoned by reset
        send_frame(8'h12, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FULL);
        send_frame(8'h34, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FULL);
        send_frame(8'h56, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40);
        @(negedge clk);
        RST = 1'b1;
        RX_IN = 1'b1;
        model_pdata = '0;
        #1;
        check_reset("midframe_reset");
        repeat (2) @(negedge clk);
        check_reset("midframe_reset_hold");
        RST = 1'b0;
        idle(100);
        check("after_reset_quiet", 32'(sb.size()), 32'd0);

        // Randomized frames
        b2b = 1'b0;
        p = 8; pe = 1'b0; pt = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!b2b) begin
                p  = int'(rand_presc());
                pe = 1'($urandom);
                pt = 1'($urandom);
                if ($urandom_range(0, 9) == 0) begin
                    glitch($urandom_range(1, p / 2 - 1), p);
                    continue;
                end
            end
            d = N'($urandom);
            send_frame(d, p, pe, pt,
                       pe && ($urandom_range(0, 4) == 0),
                       $urandom_range(0, 4) == 0,
                       1'($urandom), FULL);
            gap = $urandom_range(0, 3);
            b2b = (gap == 0);
            if (gap != 0) idle(gap);
        end
        idle(10);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
